mem_arbiter: RTL and testbench

- Two-port arbiter sharing one multi-cycle main memory between the instruction-cache miss path (I port, read-only) and the data-cache miss path (D port, read/write).
- Sits between both cache controllers and the single main memory instance in the CPU top level.
- Serialises block transfers using the memory's busywait handshake.
- Stalls the losing requester through its own busywait.

---
 rtl/mem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one multi-cycle main memory between the I-cache miss
// path (read-only) and the D-cache miss path (read/write). One block transfer
// at a time; the losing requester is stalled through its own busywait.
// Optional build macro ARB_ROUND_ROBIN_EN: replaces fixed D-over-I priority
// with a one-bit last-served pointer that alternates the winner on a tie.
module mem_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    // I port (instruction-cache miss path)
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [DATA_W-1:0] i_readdata,
    output logic              i_busywait,
    // D port (data-cache miss path)
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_writedata,
    output logic [DATA_W-1:0] d_readdata,
    output logic              d_busywait,
    // Main memory side
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    input  logic              mem_busywait,
    // Current owner: 00 none, 01 I, 10 D
    output logic [1:0]        grant
);

    typedef enum logic [2:0] {
        IDLE,
        GNT_I,
        GNT_D,
        DONE_I,
        DONE_D
    } state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_I    = 2'b01;
    localparam logic [1:0] OWN_D    = 2'b10;

    state_t            state_q;
    logic              seen_q;       // memory has raised busywait for this transfer
    logic [1:0]        grant_q;
    logic [DATA_W-1:0] i_readdata_q;
    logic [DATA_W-1:0] d_readdata_q;

    logic              d_req;
    logic              pick_d;       // D wins arbitration in IDLE this cycle

    assign d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d_q;                  // 1: D was served last, 0: I was served last

    // On a tie the port not served last wins; a lone request always wins.
    assign pick_d = d_req & (~i_read | ~last_d_q);

    // Last-served pointer, updated on entry to DONE_x.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            last_d_q <= 1'b0;
        end else if (state_q == GNT_I && seen_q && !mem_busywait) begin
            last_d_q <= 1'b0;
        end else if (state_q == GNT_D && seen_q && !mem_busywait) begin
            last_d_q <= 1'b1;
        end
    end
`else
    // Fixed priority: any D request beats an I request.
    assign pick_d = d_req;
`endif

    // Arbitration FSM with registered grant and readdata holding registers.
    // NOTE: every register here is assigned with <= so all of them sample the
    // pre-edge values of state_q and seen_q, regardless of statement order.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            // NOTE: the readdata holding registers are plain flops, not a
            // memory array, so clearing them in reset is cheap and makes the
            // post-reset outputs defined.
            state_q      <= IDLE;
            seen_q       <= 1'b0;
            grant_q      <= OWN_NONE;
            i_readdata_q <= '0;
            d_readdata_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pick_d) begin
                        state_q <= GNT_D;
                        grant_q <= OWN_D;
                    end else if (i_read) begin
                        state_q <= GNT_I;
                        grant_q <= OWN_I;
                    end
                end
                GNT_I: begin
                    if (seen_q && !mem_busywait) begin
                        i_readdata_q <= mem_readdata;
                        seen_q       <= 1'b0;
                        state_q      <= DONE_I;
                    end else if (mem_busywait) begin
                        seen_q <= 1'b1;
                    end
                end
                GNT_D: begin
                    if (seen_q && !mem_busywait) begin
                        // A simultaneous read+write was issued as a write.
                        if (d_read && !d_write) begin
                            d_readdata_q <= mem_readdata;
                        end
                        seen_q  <= 1'b0;
                        state_q <= DONE_D;
                    end else if (mem_busywait) begin
                        seen_q <= 1'b1;
                    end
                end
                DONE_I, DONE_D: begin
                    state_q <= IDLE;
                    grant_q <= OWN_NONE;
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= OWN_NONE;
                    seen_q  <= 1'b0;
                end
            endcase
        end
    end

    // Memory request mux: the granted port drives memory straight through.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no
        // latch is inferred for the states that leave memory idle.
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_writedata = '0;
        unique case (state_q)
            GNT_I: begin
                mem_read    = i_read;
                mem_address = i_address;
            end
            GNT_D: begin
                mem_write     = d_write;
                mem_read      = d_read & ~d_write;
                mem_address   = d_address;
                mem_writedata = d_writedata;
            end
            default: ;
        endcase
    end

    // Each requester is stalled until its own DONE cycle.
    assign i_busywait = i_read & (state_q != DONE_I);
    assign d_busywait = d_req  & (state_q != DONE_D);

    assign grant      = grant_q;
    assign i_readdata = i_readdata_q;
    assign d_readdata = d_readdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a small multi-cycle
// memory model. Expected ordering under contention follows the build macro
// ARB_ROUND_ROBIN_EN.
module tb_mem_arbiter;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;

    logic              CLK = 1'b0;
    logic              RESET = 1'b0;
    logic              i_read = 1'b0;
    logic [ADDR_W-1:0] i_address = '0;
    logic [DATA_W-1:0] i_readdata;
    logic              i_busywait;
    logic              d_read = 1'b0;
    logic              d_write = 1'b0;
    logic [ADDR_W-1:0] d_address = '0;
    logic [DATA_W-1:0] d_writedata = '0;
    logic [DATA_W-1:0] d_readdata;
    logic              d_busywait;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_writedata;
    logic [DATA_W-1:0] mem_readdata;
    logic              mem_busywait;
    logic [1:0]        grant;

    int checks = 0;
    int fails  = 0;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .i_read       (i_read),
        .i_address    (i_address),
        .i_readdata   (i_readdata),
        .i_busywait   (i_busywait),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_address    (d_address),
        .d_writedata  (d_writedata),
        .d_readdata   (d_readdata),
        .d_busywait   (d_busywait),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_writedata(mem_writedata),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait),
        .grant        (grant)
    );

    always #5 CLK = ~CLK;

    // ---------------- memory model ----------------
    // Accepts a strobe, stays busy for mem_lat edges, then completes and
    // waits for the strobes to drop before accepting the next request.
    int                mem_lat = 4;
    int                mem_cnt;
    logic              mem_done;
    logic              acc_write;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic [ADDR_W-1:0] last_wr_addr;
    logic [DATA_W-1:0] last_wr_data;

    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        if (a == 6'h05) return 32'hDEADBEEF;
        return {16'hC0DE, 10'h000, a};
    endfunction

    always @(posedge CLK) begin
        if (!RESET) begin
            mem_busywait <= 1'b0;
            mem_readdata <= '0;
            mem_done     <= 1'b0;
            mem_cnt      <= 0;
            last_wr_addr <= '0;
            last_wr_data <= '0;
        end else if (mem_busywait) begin
            if (mem_cnt == 0) begin
                mem_busywait <= 1'b0;
                mem_done     <= 1'b1;
                if (acc_write) begin
                    last_wr_addr <= acc_addr;
                    last_wr_data <= acc_wdata;
                end else begin
                    mem_readdata <= mem_word(acc_addr);
                end
            end else begin
                mem_cnt <= mem_cnt - 1;
            end
        end else if (mem_done) begin
            if (!mem_read && !mem_write) mem_done <= 1'b0;
        end else if (mem_read || mem_write) begin
            mem_busywait <= 1'b1;
            mem_cnt      <= mem_lat - 1;
            acc_write    <= mem_write;
            acc_addr     <= mem_address;
            acc_wdata    <= mem_writedata;
        end
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        RESET = 1'b0; i_read = 1'b1; d_write = 1'b1;
        i_address = 6'h05; d_address = 6'h3F;
        tick(); tick();
        checks++; if (grant !== 2'b00) begin fails++; $display("FAIL reset_grant: got %b want 00", grant); end
        checks++; if (mem_read !== 1'b0) begin fails++; $display("FAIL reset_mem_read: got %b want 0", mem_read); end
        checks++; if (mem_write !== 1'b0) begin fails++; $display("FAIL reset_mem_write: got %b want 0", mem_write); end
        checks++; if (mem_address !== 6'h00) begin fails++; $display("FAIL reset_mem_address: got %h want 00", mem_address); end
        checks++; if (i_readdata !== 32'h0) begin fails++; $display("FAIL reset_i_readdata: got %h want 0", i_readdata); end
        checks++; if (d_readdata !== 32'h0) begin fails++; $display("FAIL reset_d_readdata: got %h want 0", d_readdata); end
        i_read = 1'b0; d_write = 1'b0; RESET = 1'b1;
        tick();
    endtask

    task automatic test_single_d_write();
        int  n = 0;
        bit  done = 0;
        mem_lat = 4;
        d_address = 6'h3F; d_writedata = 32'h12345678; d_write = 1'b1;
        while (!done && n < 50) begin
            tick(); n++;
            if (n == 1) begin
                checks++; if (grant !== 2'b10) begin fails++; $display("FAIL dwr_grant: got %b want 10", grant); end
                checks++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin fails++; $display("FAIL dwr_strobes: got w=%b r=%b want w=1 r=0", mem_write, mem_read); end
                checks++; if (mem_writedata !== 32'h12345678) begin fails++; $display("FAIL dwr_wdata: got %h want 12345678", mem_writedata); end
                checks++; if (mem_address !== 6'h3F) begin fails++; $display("FAIL dwr_addr: got %h want 3f", mem_address); end
            end
            if (!d_busywait) done = 1;
        end
        d_write = 1'b0;
        checks++; if (n !== 7) begin fails++; $display("FAIL dwr_latency: got %0d cycles want 7", n); end
        checks++; if (grant !== 2'b10) begin fails++; $display("FAIL dwr_done_grant: got %b want 10", grant); end
        checks++; if (mem_write !== 1'b0) begin fails++; $display("FAIL dwr_done_strobe: got %b want 0", mem_write); end
        checks++; if (d_readdata !== 32'h0) begin fails++; $display("FAIL dwr_readdata_held: got %h want 0", d_readdata); end
        tick();
        checks++; if (last_wr_addr !== 6'h3F || last_wr_data !== 32'h12345678) begin fails++; $display("FAIL dwr_memory: got %h/%h want 3f/12345678", last_wr_addr, last_wr_data); end
        checks++; if (grant !== 2'b00) begin fails++; $display("FAIL dwr_idle_grant: got %b want 00", grant); end
    endtask

    task automatic test_single_i_read();
        int  n = 0;
        bit  done = 0;
        mem_lat = 4;
        i_address = 6'h05; i_read = 1'b1;
        while (!done && n < 50) begin
            tick(); n++;
            if (n == 1) begin
                checks++; if (grant !== 2'b01) begin fails++; $display("FAIL ird_grant: got %b want 01", grant); end
                checks++; if (mem_read !== 1'b1 || mem_write !== 1'b0) begin fails++; $display("FAIL ird_strobes: got r=%b w=%b want r=1 w=0", mem_read, mem_write); end
                checks++; if (mem_address !== 6'h05) begin fails++; $display("FAIL ird_addr: got %h want 05", mem_address); end
            end
            if (!i_busywait) done = 1;
        end
        checks++; if (n !== 7) begin fails++; $display("FAIL ird_latency: got %0d cycles want 7", n); end
        checks++; if (i_readdata !== 32'hDEADBEEF) begin fails++; $display("FAIL ird_data: got %h want deadbeef", i_readdata); end
        checks++; if (mem_read !== 1'b0) begin fails++; $display("FAIL ird_done_strobe: got %b want 0", mem_read); end
        tick();
        // Request still up for one more cycle: busywait must be high again.
        checks++; if (i_busywait !== 1'b1) begin fails++; $display("FAIL ird_busy_one_cycle: got %b want 1", i_busywait); end
        checks++; if (grant !== 2'b00) begin fails++; $display("FAIL ird_idle_grant: got %b want 00", grant); end
        i_read = 1'b0;
        tick();
    endtask

    task automatic test_contention();
        logic [1:0] order[$];
        logic [1:0] prev_grant = 2'b00;
        logic [1:0] exp_order[3];
        logic [1:0] got;
        int  d_cnt = 0;
        bit  i_done = 0;
        bit  i_stall_ok = 1;
        int  n = 0;
`ifdef ARB_ROUND_ROBIN_EN
        exp_order[0] = 2'b10; exp_order[1] = 2'b01; exp_order[2] = 2'b10;
`else
        exp_order[0] = 2'b10; exp_order[1] = 2'b10; exp_order[2] = 2'b01;
`endif
        mem_lat = 2;
        i_address = 6'h0A; i_read = 1'b1;
        d_address = 6'h14; d_read = 1'b1;
        while (!(i_done && d_cnt == 2) && n < 100) begin
            tick(); n++;
            if (grant != 2'b00 && prev_grant == 2'b00) order.push_back(grant);
            if (grant == 2'b10 && i_read && !i_busywait) i_stall_ok = 0;
            prev_grant = grant;
            if (d_read && !d_busywait) begin
                checks++;
                if (d_readdata !== ((d_cnt == 0) ? 32'hC0DE0014 : 32'hC0DE0015)) begin
                    fails++; $display("FAIL cont_d_data%0d: got %h", d_cnt, d_readdata);
                end
                d_cnt++;
                // D re-requests at once, creating a second tie with I.
                if (d_cnt < 2) d_address = 6'h15; else d_read = 1'b0;
            end
            if (i_read && !i_busywait) begin
                checks++; if (i_readdata !== 32'hC0DE000A) begin fails++; $display("FAIL cont_i_data: got %h want c0de000a", i_readdata); end
                i_read = 1'b0; i_done = 1;
            end
        end
        i_read = 1'b0; d_read = 1'b0;
        checks++; if (!(i_done && d_cnt == 2)) begin fails++; $display("FAIL cont_timeout: i_done=%0d d_cnt=%0d want 1/2", i_done, d_cnt); end
        checks++; if (order.size() != 3) begin fails++; $display("FAIL cont_grants: got %0d grants want 3", order.size()); end
        for (int k = 0; k < 3; k++) begin
            got = (order.size() > k) ? order[k] : 2'b11;
            checks++; if (got !== exp_order[k]) begin fails++; $display("FAIL cont_order%0d: got %b want %b", k, got, exp_order[k]); end
        end
        checks++; if (i_stall_ok !== 1'b1) begin fails++; $display("FAIL cont_i_stall: i_busywait dropped during D grant"); end
        tick();
    endtask

    task automatic test_rw_conflict();
        int n = 0;
        bit done = 0;
        mem_lat = 2;
        d_address = 6'h22; d_writedata = 32'hCAFEF00D; d_read = 1'b1; d_write = 1'b1;
        while (!done && n < 50) begin
            tick(); n++;
            if (n == 1) begin
                checks++; if (grant !== 2'b10) begin fails++; $display("FAIL rw_grant: got %b want 10", grant); end
                checks++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin fails++; $display("FAIL rw_strobes: got w=%b r=%b want w=1 r=0", mem_write, mem_read); end
            end
            if (!d_busywait) done = 1;
        end
        d_read = 1'b0; d_write = 1'b0;
        checks++; if (!done) begin fails++; $display("FAIL rw_timeout: no completion in %0d cycles", n); end
        tick();
        checks++; if (last_wr_addr !== 6'h22 || last_wr_data !== 32'hCAFEF00D) begin fails++; $display("FAIL rw_memory: got %h/%h want 22/cafef00d", last_wr_addr, last_wr_data); end
    endtask

    task automatic test_reset_mid_transfer();
        int n = 0;
        bit done = 0;
        mem_lat = 6;
        d_address = 6'h30; d_read = 1'b1;
        tick(); tick(); tick();
        checks++; if (grant !== 2'b10 || mem_busywait !== 1'b1) begin fails++; $display("FAIL mid_setup: got grant=%b busy=%b want 10/1", grant, mem_busywait); end
        RESET = 1'b0;
        tick();
        checks++; if (grant !== 2'b00) begin fails++; $display("FAIL mid_grant: got %b want 00", grant); end
        checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin fails++; $display("FAIL mid_strobes: got r=%b w=%b want 0/0", mem_read, mem_write); end
        checks++; if (mem_address !== 6'h00) begin fails++; $display("FAIL mid_addr: got %h want 00", mem_address); end
        checks++; if (i_readdata !== 32'h0 || d_readdata !== 32'h0) begin fails++; $display("FAIL mid_readdata: got %h/%h want 0/0", i_readdata, d_readdata); end
        d_read = 1'b0; RESET = 1'b1;
        tick();
        // A stale seen flag would end this read on its first edge.
        mem_lat = 4;
        i_address = 6'h05; i_read = 1'b1;
        while (!done && n < 50) begin
            tick(); n++;
            if (!i_busywait) done = 1;
        end
        i_read = 1'b0;
        checks++; if (n !== 7) begin fails++; $display("FAIL mid_after_latency: got %0d cycles want 7", n); end
        checks++; if (i_readdata !== 32'hDEADBEEF) begin fails++; $display("FAIL mid_after_data: got %h want deadbeef", i_readdata); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_d_write();
        test_single_i_read();
        test_contention();
        test_rw_conflict();
        test_reset_mid_transfer();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
